alu_mul_seq: RTL and testbench

- Multi-cycle 16x16 multiply sequencer. Produces the low 16 bits of the product by driving the shared 16-bit ALU with repeated ADD and SLL operations (shift-and-add).
- Sits beside the execute stage. It owns no adder or shifter and uses the ALU only through a request/grant port, so the ALU stays shared with the normal instruction path.
- Start/busy/done handshake toward the pipeline controller.

---
 rtl/alu_mul_seq.sv | 145 ++++++++++++++
 tb/tb_alu_mul_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// Multi-cycle 16x16 multiplier (low half) built on a shared ALU via request/grant.
// Shift-and-add: each multiplier bit costs one ADD and one SLL ALU cycle.
module alu_mul_seq #(
    parameter int ITER       = 16,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [15:0] alu_result,
    output logic [1:0]  dbg_state
);
    localparam int CW = $clog2(ITER) + 1;
    localparam logic [3:0] CTRL_ADD = 4'b0000;
    localparam logic [3:0] CTRL_SLL = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     acc_q, acc_d;
    logic [15:0]     mcand_q, mcand_d;
    logic [15:0]     mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            alu_req_q, alu_req_d;
    logic [15:0]     alu_a_q, alu_a_d;
    logic [15:0]     alu_b_q, alu_b_d;
    logic [3:0]      alu_ctrl_q, alu_ctrl_d;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = 16'h0000;
                    cnt_d    = '0;
                    state_d  = S_ADD;
                end
            end
            S_ADD: begin
                if (alu_gnt) begin
                    if (mplier_q[0]) acc_d = alu_result;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (alu_gnt) begin
                    mcand_d  = alu_result;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if ((cnt_q == CW'(ITER - 1)) || (EARLY_EXIT && (mplier_d == 16'h0000)))
                        state_d = S_DONE;
                    else
                        state_d = S_ADD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        alu_req_d  = (state_d == S_ADD) || (state_d == S_SHIFT);
        alu_a_d    = 16'h0000;
        alu_b_d    = 16'h0000;
        alu_ctrl_d = CTRL_ADD;
        case (state_d)
            S_ADD: begin
                alu_a_d = acc_d;
                alu_b_d = mcand_d;
            end
            S_SHIFT: begin
                alu_a_d    = mcand_d;
                alu_b_d    = 16'h0001;
                alu_ctrl_d = CTRL_SLL;
            end
            default: ;
        endcase
        if (state_d == S_DONE) result_d = acc_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= 16'h0000;
            mcand_q    <= 16'h0000;
            mplier_q   <= 16'h0000;
            cnt_q      <= '0;
            result_q   <= 16'h0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            alu_req_q  <= 1'b0;
            alu_a_q    <= 16'h0000;
            alu_b_q    <= 16'h0000;
            alu_ctrl_q <= CTRL_ADD;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            alu_req_q  <= alu_req_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctrl_q <= alu_ctrl_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign alu_req   = alu_req_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq: one instance without and one with early exit,
// each attached to a small behavioural ALU with a bench-controlled grant.
module tb_alu_mul_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_s    [2];
    logic [15:0] op_a_s     [2];
    logic [15:0] op_b_s     [2];
    logic        busy_s     [2];
    logic        done_s     [2];
    logic [15:0] result_s   [2];
    logic        alu_req_s  [2];
    logic        gnt_s      [2];
    logic [15:0] alu_a_s    [2];
    logic [15:0] alu_b_s    [2];
    logic [3:0]  alu_ctrl_s [2];
    logic [15:0] alu_res_s  [2];
    logic [1:0]  dbg_s      [2];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_mul_seq #(.ITER(16), .EARLY_EXIT(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .op_a(op_a_s[0]), .op_b(op_b_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .result(result_s[0]), .alu_req(alu_req_s[0]),
        .alu_gnt(gnt_s[0]), .alu_a(alu_a_s[0]), .alu_b(alu_b_s[0]), .alu_ctrl(alu_ctrl_s[0]),
        .alu_result(alu_res_s[0]), .dbg_state(dbg_s[0])
    );

    alu_mul_seq #(.ITER(16), .EARLY_EXIT(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .op_a(op_a_s[1]), .op_b(op_b_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .result(result_s[1]), .alu_req(alu_req_s[1]),
        .alu_gnt(gnt_s[1]), .alu_a(alu_a_s[1]), .alu_b(alu_b_s[1]), .alu_ctrl(alu_ctrl_s[1]),
        .alu_result(alu_res_s[1]), .dbg_state(dbg_s[1])
    );

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            alu_res_s[i] = 16'h0000;
            if (alu_ctrl_s[i] == 4'b0000)      alu_res_s[i] = alu_a_s[i] + alu_b_s[i];
            else if (alu_ctrl_s[i] == 4'b1100) alu_res_s[i] = alu_a_s[i] << alu_b_s[i][3:0];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Runs one multiply; stall[n]=1 drops grant during cycle n, extra[n]=1 pulses
    // start with 9x9 during cycle n. Cycle n is the one following clock edge n.
    task automatic do_op(input int s, input logic [15:0] a, input logic [15:0] b,
                         input logic [63:0] stall, input logic [63:0] extra,
                         output int done_cyc, output int busy_n, output int req_n,
                         output int done_n, output int unstable, output logic [15:0] res);
        logic [37:0] snap;
        logic        prev_stall;
        done_cyc = -1; busy_n = 0; req_n = 0; done_n = 0; unstable = 0;
        prev_stall = 1'b0; snap = '0; res = 16'hxxxx;
        @(negedge clk);
        op_a_s[s] = a; op_b_s[s] = b; start_s[s] = 1'b1; gnt_s[s] = 1'b1;
        @(posedge clk);
        #1 start_s[s] = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (prev_stall && snap != {alu_a_s[s], alu_b_s[s], alu_ctrl_s[s], dbg_s[s]})
                unstable++;
            busy_n += int'(busy_s[s]);
            req_n  += int'(alu_req_s[s]);
            if (done_s[s]) begin
                done_n++;
                if (done_cyc < 0) done_cyc = n;
                res = result_s[s];
            end
            prev_stall = stall[n];
            snap = {alu_a_s[s], alu_b_s[s], alu_ctrl_s[s], dbg_s[s]};
            gnt_s[s] = !stall[n];
            if (extra[n]) begin
                start_s[s] = 1'b1; op_a_s[s] = 16'd9; op_b_s[s] = 16'd9;
            end else begin
                start_s[s] = 1'b0;
            end
            if (done_cyc >= 0) break;
        end
        gnt_s[s] = 1'b1;
        if (done_cyc < 0) res = result_s[s];
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        int          cyc;
    } vec_t;

    initial begin
        vec_t        v0 [4];
        vec_t        v1 [4];
        int          dc, bn, rn, dn, un, dcount;
        logic [15:0] r;
        logic [63:0] stall_m, extra_m;

        v0[0] = '{16'h0003, 16'h0005, 16'h000F, 33};
        v0[1] = '{16'h1234, 16'h0010, 16'h2340, 33};
        v0[2] = '{16'hFFFF, 16'hFFFF, 16'h0001, 33};
        v0[3] = '{16'h8000, 16'h0002, 16'h0000, 33};
        v1[0] = '{16'h0007, 16'h0002, 16'h000E, 5};
        v1[1] = '{16'h1234, 16'h0000, 16'h0000, 3};
        v1[2] = '{16'h0003, 16'h0005, 16'h000F, 7};
        v1[3] = '{16'hFFFF, 16'h8000, 16'h8000, 33};

        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; op_a_s[i] = 16'h0000; op_b_s[i] = 16'h0000; gnt_s[i] = 1'b1;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy_s[0], 1'b0);
        chk("reset_done", done_s[0], 1'b0);
        chk("reset_result", result_s[0], 16'h0000);
        chk("reset_req", alu_req_s[0], 1'b0);
        chk("reset_ctrl", alu_ctrl_s[0], 4'b0000);
        chk("reset_alu_a", alu_a_s[0], 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            do_op(0, v0[i].a, v0[i].b, 64'h0, 64'h0, dc, bn, rn, dn, un, r);
            chk($sformatf("ee0_v%0d_result", i), r, v0[i].res);
            chk($sformatf("ee0_v%0d_done_cycle", i), dc, v0[i].cyc);
            chk($sformatf("ee0_v%0d_busy_cycles", i), bn, 33);
            chk($sformatf("ee0_v%0d_req_cycles", i), rn, 32);
            chk($sformatf("ee0_v%0d_done_pulses", i), dn, 1);
        end

        // Five scattered grant drops stretch the operation by five cycles.
        stall_m = '0;
        stall_m[2] = 1'b1; stall_m[7] = 1'b1; stall_m[15] = 1'b1;
        stall_m[20] = 1'b1; stall_m[31] = 1'b1;
        do_op(0, 16'd3, 16'd5, stall_m, 64'h0, dc, bn, rn, dn, un, r);
        chk("stall_result", r, 16'h000F);
        chk("stall_done_cycle", dc, 38);
        chk("stall_req_cycles", rn, 37);
        chk("stall_unstable", un, 0);

        // Starts during busy and during done are ignored; the one right after is taken.
        extra_m = '0;
        extra_m[10] = 1'b1; extra_m[33] = 1'b1;
        do_op(0, 16'd3, 16'd5, 64'h0, extra_m, dc, bn, rn, dn, un, r);
        chk("ign_start_result", r, 16'h000F);
        chk("ign_start_done_cycle", dc, 33);
        do_op(0, 16'd9, 16'd9, 64'h0, 64'h0, dc, bn, rn, dn, un, r);
        chk("next_start_result", r, 16'h0051);
        chk("next_start_done_cycle", dc, 33);

        // Reset mid-operation abandons the multiply without a done pulse.
        @(negedge clk);
        op_a_s[0] = 16'd3; op_b_s[0] = 16'd5; start_s[0] = 1'b1;
        @(posedge clk);
        #1 start_s[0] = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy_s[0], 1'b0);
        chk("midrst_done", done_s[0], 1'b0);
        chk("midrst_result", result_s[0], 16'h0000);
        chk("midrst_req", alu_req_s[0], 1'b0);
        chk("midrst_ctrl", alu_ctrl_s[0], 4'b0000);
        rst = 1'b0;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            dcount += int'(done_s[0]);
        end
        chk("midrst_no_done", dcount, 0);
        do_op(0, 16'd2, 16'd7, 64'h0, 64'h0, dc, bn, rn, dn, un, r);
        chk("after_rst_result", r, 16'h000E);
        chk("after_rst_done_cycle", dc, 33);

        for (int i = 0; i < 4; i++) begin
            do_op(1, v1[i].a, v1[i].b, 64'h0, 64'h0, dc, bn, rn, dn, un, r);
            chk($sformatf("ee1_v%0d_result", i), r, v1[i].res);
            chk($sformatf("ee1_v%0d_done_cycle", i), dc, v1[i].cyc);
            chk($sformatf("ee1_v%0d_done_pulses", i), dn, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
